psl_command_responder: RTL and testbench

Synthesizable responder for the PSL command/response tag interface. It accepts tagged commands from the AFU command path and returns one response per command, carrying the same 8-bit tag, after a fixed latency. It checks tag discipline: no duplicate outstanding tag and no queue overflow. It sits opposite the AFU tag allocator in simulation and emulation builds, standing in for the PSL so that tag issue/recycle loops can close without hardware.

---
 rtl/psl_command_responder_if.sv | 20 ++
 rtl/psl_command_responder.sv | 145 ++++++++++++++
 tb/tb_psl_command_responder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/psl_command_responder_if.sv
// PSL command/response tag channel between the AFU command path and the responder.
// Valid-only handshake: command_valid and response_valid each mark a one-cycle transfer; there is no ready and the receiver must take every beat.
interface psl_command_responder_if;
    logic       command_valid;
    logic [7:0] command_tag;
    logic       response_valid;
    logic [7:0] response_tag;
    logic [7:0] response_code;
    logic       response_credits;

    modport master (
        output command_valid, command_tag,
        input  response_valid, response_tag, response_code, response_credits
    );

    modport slave (
        input  command_valid, command_tag,
        output response_valid, response_tag, response_code, response_credits
    );
endinterface

// File: rtl/psl_command_responder.sv
// Stand-in PSL responder: returns each accepted tag after a fixed latency, in order,
// and flags duplicate outstanding tags and pending-queue overflow.
module psl_command_responder #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 64
) (
    input  logic                   clock,
    input  logic                   rstn,
    input  logic                   enabled,
    psl_command_responder_if.slave cmd,
    output logic [8:0]             credits_available,
    output logic                   tag_error,
    output logic                   overflow_error,
    output logic                   dbg_state
);

    typedef enum logic {ST_FLUSH = 1'b0, ST_RUN = 1'b1} state_t;

    typedef struct packed {
        logic [7:0]  tag;
        logic [15:0] stamp;
    } entry_t;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t         state_q, state_d;
    logic [15:0]    now_q, now_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [255:0]   outstanding_q, outstanding_d;
    logic           resp_valid_q, resp_valid_d;
    logic [7:0]     resp_tag_q, resp_tag_d;
    logic [8:0]     credits_q, credits_d;
    logic           tag_err_q, tag_err_d;
    logic           ovf_err_q, ovf_err_d;
    entry_t         fifo_q [DEPTH];

    entry_t         head;
    logic [15:0]    age;
    logic           full, issue, dup, push;
    logic [255:0]   clear_vec, set_vec;

    // A tag being returned this cycle no longer counts as outstanding, so it may be reissued at once.
    always_comb begin
        head      = fifo_q[rd_ptr_q];
        age       = now_q - head.stamp;
        full      = (count_q == (AW+1)'(DEPTH));
        issue     = enabled && (count_q != '0) && (age >= 16'(LATENCY - 1));
        clear_vec = '0;
        if (issue) clear_vec[head.tag] = 1'b1;
        dup       = outstanding_q[cmd.command_tag] & ~clear_vec[cmd.command_tag];
        push      = enabled & cmd.command_valid & ~full & ~dup;
        set_vec   = '0;
        if (push) set_vec[cmd.command_tag] = 1'b1;
    end

    always_comb begin
        state_d       = state_q;
        now_d         = now_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        resp_valid_d  = 1'b0;
        resp_tag_d    = 8'h00;
        credits_d     = credits_q;
        tag_err_d     = tag_err_q;
        ovf_err_d     = ovf_err_q;

        case (state_q)
            ST_FLUSH: if (enabled)  state_d = ST_RUN;
            ST_RUN:   if (!enabled) state_d = ST_FLUSH;
            default:                state_d = ST_FLUSH;
        endcase

        if (!enabled) begin
            now_d         = 16'h0000;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            outstanding_d = '0;
            credits_d     = 9'(DEPTH);
            tag_err_d     = 1'b0;
            ovf_err_d     = 1'b0;
        end else begin
            now_d = now_q + 16'd1;
            if (push)  wr_ptr_d = wr_ptr_q + AW'(1);
            if (issue) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, issue})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
            outstanding_d = (outstanding_q & ~clear_vec) | set_vec;
            resp_valid_d  = issue;
            resp_tag_d    = issue ? head.tag : 8'h00;
            credits_d     = 9'(DEPTH) - 9'(count_d);
            tag_err_d     = tag_err_q | (cmd.command_valid & dup);
            ovf_err_d     = ovf_err_q | (cmd.command_valid & full);
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_FLUSH;
            now_q         <= 16'h0000;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            resp_valid_q  <= 1'b0;
            resp_tag_q    <= 8'h00;
            credits_q     <= 9'(DEPTH);
            tag_err_q     <= 1'b0;
            ovf_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            now_q         <= now_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            resp_valid_q  <= resp_valid_d;
            resp_tag_q    <= resp_tag_d;
            credits_q     <= credits_d;
            tag_err_q     <= tag_err_d;
            ovf_err_q     <= ovf_err_d;
        end
    end

    // Queue storage needs no reset: entries are only read while count_q is non-zero.
    always_ff @(posedge clock) begin
        if (push) fifo_q[wr_ptr_q] <= '{tag: cmd.command_tag, stamp: now_q};
    end

    assign cmd.response_valid   = resp_valid_q;
    assign cmd.response_tag     = resp_tag_q;
    assign cmd.response_code    = 8'h00;
    assign cmd.response_credits = resp_valid_q;
    assign credits_available    = credits_q;
    assign tag_error            = tag_err_q;
    assign overflow_error       = ovf_err_q;
    assign dbg_state            = (state_q == ST_RUN);

endmodule

// File: tb/tb_psl_command_responder.sv
// Directed bench for psl_command_responder: instance a (LATENCY 4, DEPTH 64), instance b (LATENCY 100, DEPTH 4).
module tb_psl_command_responder;
  logic       clock = 1'b0;
  logic       rstn  = 1'b1;
  logic       en_a  = 1'b0;
  logic       en_b  = 1'b0;
  logic [8:0] cred_a, cred_b;
  logic       terr_a, oerr_a, st_a;
  logic       terr_b, oerr_b, st_b;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;

  psl_command_responder_if if_a ();
  psl_command_responder_if if_b ();

  psl_command_responder #(.LATENCY(4), .DEPTH(64)) u_a (
    .clock(clock), .rstn(rstn), .enabled(en_a), .cmd(if_a.slave),
    .credits_available(cred_a), .tag_error(terr_a), .overflow_error(oerr_a), .dbg_state(st_a)
  );

  psl_command_responder #(.LATENCY(100), .DEPTH(4)) u_b (
    .clock(clock), .rstn(rstn), .enabled(en_b), .cmd(if_b.slave),
    .credits_available(cred_b), .tag_error(terr_b), .overflow_error(oerr_b), .dbg_state(st_b)
  );

  // clock / reset
  always #5 clock = ~clock;

  // driver tasks
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [7:0] t);
    if_a.command_valid = v;
    if_a.command_tag   = t;
  endtask

  task automatic drive_b(input logic v, input logic [7:0] t);
    if_b.command_valid = v;
    if_b.command_tag   = t;
  endtask

  task automatic test_reset;
    #1 rstn = 1'b0;
    #1;
    checks++; if (if_a.response_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", if_a.response_valid); end
    checks++; if (if_a.response_tag !== 8'h00) begin errors++; $display("FAIL rst_tag: got %0h want 0", if_a.response_tag); end
    checks++; if (if_a.response_code !== 8'h00) begin errors++; $display("FAIL rst_code: got %0h want 0", if_a.response_code); end
    checks++; if (if_a.response_credits !== 1'b0) begin errors++; $display("FAIL rst_rcredit: got %0b want 0", if_a.response_credits); end
    checks++; if (cred_a !== 9'd64) begin errors++; $display("FAIL rst_credits_a: got %0d want 64", cred_a); end
    checks++; if (cred_b !== 9'd4) begin errors++; $display("FAIL rst_credits_b: got %0d want 4", cred_b); end
    checks++; if (terr_a !== 1'b0 || oerr_a !== 1'b0) begin errors++; $display("FAIL rst_errors: got %0b%0b want 00", terr_a, oerr_a); end
    checks++; if (st_a !== 1'b0) begin errors++; $display("FAIL rst_state: got %0b want 0", st_a); end
    tick; tick;
    rstn = 1'b0;
    rstn = 1'b1;
    en_a = 1'b1;
    en_b = 1'b1;
    tick; tick;
    checks++; if (st_a !== 1'b1) begin errors++; $display("FAIL run_state: got %0b want 1", st_a); end
    checks++; if (cred_a !== 9'd64) begin errors++; $display("FAIL run_credits: got %0d want 64", cred_a); end
  endtask

  task automatic test_single;
    drive_a(1'b1, 8'h05); tick; drive_a(1'b0, 8'h00);
    checks++; if (cred_a !== 9'd63) begin errors++; $display("FAIL single_credits_push: got %0d want 63", cred_a); end
    checks++; if (if_a.response_valid !== 1'b0) begin errors++; $display("FAIL single_early0: got %0b want 0", if_a.response_valid); end
    tick;
    checks++; if (if_a.response_valid !== 1'b0) begin errors++; $display("FAIL single_early1: got %0b want 0", if_a.response_valid); end
    tick;
    checks++; if (if_a.response_valid !== 1'b0) begin errors++; $display("FAIL single_early2: got %0b want 0", if_a.response_valid); end
    tick;
    checks++; if (if_a.response_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", if_a.response_valid); end
    checks++; if (if_a.response_tag !== 8'h05) begin errors++; $display("FAIL single_tag: got %0h want 05", if_a.response_tag); end
    checks++; if (if_a.response_code !== 8'h00) begin errors++; $display("FAIL single_code: got %0h want 00", if_a.response_code); end
    checks++; if (if_a.response_credits !== 1'b1) begin errors++; $display("FAIL single_rcredit: got %0b want 1", if_a.response_credits); end
    checks++; if (cred_a !== 9'd64) begin errors++; $display("FAIL single_credits_pop: got %0d want 64", cred_a); end
    tick;
    checks++; if (if_a.response_valid !== 1'b0) begin errors++; $display("FAIL single_oneshot: got %0b want 0", if_a.response_valid); end
  endtask

  task automatic test_back_to_back;
    logic exp_v;
    exp_q.delete();
    for (int j = 0; j < 12; j++) begin
      if (j < 8) begin
        drive_a(1'b1, 8'(j + 1));
        exp_q.push_back(8'(j + 1));
      end else begin
        drive_a(1'b0, 8'h00);
      end
      tick;
      exp_v = (j >= 3 && j <= 10);
      checks++; if (if_a.response_valid !== exp_v) begin errors++; $display("FAIL b2b_valid cycle %0d: got %0b want %0b", j, if_a.response_valid, exp_v); end
      if (if_a.response_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++; if (if_a.response_tag !== e) begin errors++; $display("FAIL b2b_tag cycle %0d: got %0h want %0h", j, if_a.response_tag, e); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing: got %0d left want 0", exp_q.size()); end
    checks++; if (terr_a !== 1'b0 || oerr_a !== 1'b0) begin errors++; $display("FAIL b2b_errors: got %0b%0b want 00", terr_a, oerr_a); end
  endtask

  task automatic test_same_cycle_reissue;
    drive_a(1'b1, 8'h22); tick; drive_a(1'b0, 8'h00);
    tick; tick;
    drive_a(1'b1, 8'h22); tick; drive_a(1'b0, 8'h00);
    checks++; if (if_a.response_valid !== 1'b1 || if_a.response_tag !== 8'h22) begin errors++; $display("FAIL reissue_first: got %0b/%0h want 1/22", if_a.response_valid, if_a.response_tag); end
    checks++; if (terr_a !== 1'b0) begin errors++; $display("FAIL reissue_no_error: got %0b want 0", terr_a); end
    tick;
    checks++; if (if_a.response_valid !== 1'b0) begin errors++; $display("FAIL reissue_gap1: got %0b want 0", if_a.response_valid); end
    tick;
    checks++; if (if_a.response_valid !== 1'b0) begin errors++; $display("FAIL reissue_gap2: got %0b want 0", if_a.response_valid); end
    tick;
    checks++; if (if_a.response_valid !== 1'b1 || if_a.response_tag !== 8'h22) begin errors++; $display("FAIL reissue_second: got %0b/%0h want 1/22", if_a.response_valid, if_a.response_tag); end
    checks++; if (terr_a !== 1'b0) begin errors++; $display("FAIL reissue_end_error: got %0b want 0", terr_a); end
    tick;
  endtask

  task automatic test_dup_tag;
    int n = 0;
    drive_a(1'b1, 8'h22); tick;
    drive_a(1'b1, 8'h22); tick; drive_a(1'b0, 8'h00);
    checks++; if (terr_a !== 1'b1) begin errors++; $display("FAIL dup_flag: got %0b want 1", terr_a); end
    for (int j = 0; j < 8; j++) begin
      if (if_a.response_valid === 1'b1 && if_a.response_tag === 8'h22) n++;
      tick;
    end
    checks++; if (n != 1) begin errors++; $display("FAIL dup_resp_count: got %0d want 1", n); end
    checks++; if (terr_a !== 1'b1 || oerr_a !== 1'b0) begin errors++; $display("FAIL dup_sticky: got %0b%0b want 10", terr_a, oerr_a); end
  endtask

  task automatic test_overflow;
    int n = 0;
    for (int j = 0; j < 5; j++) begin
      drive_b(1'b1, 8'(j + 1));
      tick;
      if (j == 3) begin
        checks++; if (cred_b !== 9'd0) begin errors++; $display("FAIL ovf_full_credits: got %0d want 0", cred_b); end
        checks++; if (oerr_b !== 1'b0) begin errors++; $display("FAIL ovf_early: got %0b want 0", oerr_b); end
      end
    end
    drive_b(1'b0, 8'h00);
    checks++; if (oerr_b !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b want 1", oerr_b); end
    checks++; if (cred_b !== 9'd0 || terr_b !== 1'b0) begin errors++; $display("FAIL ovf_state: got %0d/%0b want 0/0", cred_b, terr_b); end
    exp_q.delete();
    for (int j = 1; j <= 4; j++) exp_q.push_back(8'(j));
    for (int j = 0; j < 110; j++) begin
      tick;
      if (if_b.response_valid === 1'b1) begin
        n++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++; if (if_b.response_tag !== e) begin errors++; $display("FAIL ovf_tag: got %0h want %0h", if_b.response_tag, e); end
        end
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL ovf_resp_count: got %0d want 4", n); end
    checks++; if (cred_b !== 9'd4) begin errors++; $display("FAIL ovf_credits_back: got %0d want 4", cred_b); end
  endtask

  task automatic test_flush;
    int n = 0;
    drive_a(1'b1, 8'h30); tick;
    drive_a(1'b1, 8'h31); tick;
    drive_a(1'b1, 8'h32); tick;
    drive_a(1'b0, 8'h00);
    en_a = 1'b0; tick;
    checks++; if (if_a.response_valid !== 1'b0 || if_a.response_tag !== 8'h00) begin errors++; $display("FAIL flush_resp: got %0b/%0h want 0/00", if_a.response_valid, if_a.response_tag); end
    checks++; if (cred_a !== 9'd64) begin errors++; $display("FAIL flush_credits: got %0d want 64", cred_a); end
    checks++; if (terr_a !== 1'b0 || oerr_a !== 1'b0) begin errors++; $display("FAIL flush_errors: got %0b%0b want 00", terr_a, oerr_a); end
    checks++; if (st_a !== 1'b0) begin errors++; $display("FAIL flush_state: got %0b want 0", st_a); end
    en_a = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick;
      if (if_a.response_valid === 1'b1) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL flush_discard: got %0d responses want 0", n); end
    drive_a(1'b1, 8'h30); tick; drive_a(1'b0, 8'h00);
    tick; tick; tick;
    checks++; if (if_a.response_valid !== 1'b1 || if_a.response_tag !== 8'h30) begin errors++; $display("FAIL flush_reuse: got %0b/%0h want 1/30", if_a.response_valid, if_a.response_tag); end
    checks++; if (terr_a !== 1'b0) begin errors++; $display("FAIL flush_reuse_err: got %0b want 0", terr_a); end
    tick;
  endtask

  task automatic test_wrap;
    en_a = 1'b0; tick; en_a = 1'b1;
    repeat (65534) @(posedge clock);
    #1;
    drive_a(1'b1, 8'h10); tick; drive_a(1'b0, 8'h00);
    tick;
    checks++; if (if_a.response_valid !== 1'b0) begin errors++; $display("FAIL wrap_early1: got %0b want 0", if_a.response_valid); end
    tick;
    checks++; if (if_a.response_valid !== 1'b0) begin errors++; $display("FAIL wrap_early2: got %0b want 0", if_a.response_valid); end
    tick;
    checks++; if (if_a.response_valid !== 1'b1 || if_a.response_tag !== 8'h10) begin errors++; $display("FAIL wrap_resp: got %0b/%0h want 1/10", if_a.response_valid, if_a.response_tag); end
    tick;
    checks++; if (if_a.response_valid !== 1'b0) begin errors++; $display("FAIL wrap_after: got %0b want 0", if_a.response_valid); end
  endtask

  task automatic test_async_reset;
    int n = 0;
    drive_a(1'b1, 8'h40); tick;
    drive_a(1'b1, 8'h41); tick;
    drive_a(1'b1, 8'h40); tick;
    drive_a(1'b0, 8'h00); tick;
    checks++; if (if_a.response_valid !== 1'b1 || terr_a !== 1'b1 || cred_a !== 9'd63) begin errors++; $display("FAIL arst_pre: got %0b/%0b/%0d want 1/1/63", if_a.response_valid, terr_a, cred_a); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (if_a.response_valid !== 1'b0 || if_a.response_tag !== 8'h00) begin errors++; $display("FAIL arst_resp: got %0b/%0h want 0/00", if_a.response_valid, if_a.response_tag); end
    checks++; if (if_a.response_credits !== 1'b0) begin errors++; $display("FAIL arst_rcredit: got %0b want 0", if_a.response_credits); end
    checks++; if (cred_a !== 9'd64 || cred_b !== 9'd4) begin errors++; $display("FAIL arst_credits: got %0d/%0d want 64/4", cred_a, cred_b); end
    checks++; if (terr_a !== 1'b0 || oerr_a !== 1'b0 || st_a !== 1'b0) begin errors++; $display("FAIL arst_flags: got %0b%0b%0b want 000", terr_a, oerr_a, st_a); end
    tick; tick;
    rstn = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick;
      if (if_a.response_valid === 1'b1) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL arst_discard: got %0d responses want 0", n); end
  endtask

  // scenario sequence and final report
  initial begin
    drive_a(1'b0, 8'h00);
    drive_b(1'b0, 8'h00);
    test_reset;
    test_single;
    test_back_to_back;
    test_same_cycle_reissue;
    test_dup_tag;
    test_overflow;
    test_flush;
    test_wrap;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
